// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmitter family.
//   - Parity selection constants.
//   - 3-bit transmitter FSM state encoding.
//   - Bit-counter width and a frame-length helper for receivers and benches.
package rs232_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Wide enough for up to 8 data bits or 2 stop bits.
  localparam int BIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } tx_state_t;

  // Clocks occupied by one complete frame on the line.
  function automatic int frame_clocks(input int data_w, input int clk_div,
                                      input int parity, input int stop_bits);
    return (1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/rs232_tx_fifo_if.sv
// Host-side bus of rs232_tx_fifo.
//   i_data/i_wr_en : word to enqueue and its request (host -> transmitter)
//   o_full         : FIFO holds its maximum number of entries
//   o_busy         : frame in progress or words still queued
//   o_tx           : serial line, idles high
//   o_done         : one-cycle pulse in the last clock of the final stop bit
//   o_ovf          : one-cycle pulse for a write dropped because FIFO was full
interface rs232_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_wr_en;
  logic              o_full;
  logic              o_busy;
  logic              o_tx;
  logic              o_done;
  logic              o_ovf;

  modport master (output i_data, i_wr_en,
                  input  o_full, o_busy, o_tx, o_done, o_ovf);
  modport slave  (input  i_data, i_wr_en,
                  output o_full, o_busy, o_tx, o_done, o_ovf);
endinterface

// File: rtl/tx_fifo.sv
// Synchronous FIFO buffering words ahead of the serialiser.
//   i_clk/i_rst_n : clock, asynchronous active-low reset
//   i_wr_en/i_wr_data : push request (ignored when full) and its data
//   i_rd_en       : pop request (ignored when empty)
//   o_rd_data     : head of the queue, valid whenever o_empty is low
//   o_full/o_empty/o_count : status derived from the registered entry count
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO drops the write even when a pop happens in the same cycle.
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rs232_tx_fifo.sv
// Buffered RS-232 transmitter: queues words in tx_fifo and sends them as
// start / DATA_W data bits (LSB first) / optional parity / stop bit(s),
// each bit held CLK_DIV clocks, with no idle gap between queued frames.
//   i_clk/i_rst_n : clock, asynchronous active-low reset
//   bus (slave)   : i_data, i_wr_en in; o_full, o_busy, o_tx, o_done, o_ovf out
module rs232_tx_fifo
  import rs232_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rs232_tx_fifo_if.slave  bus
);
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_t          r_state, w_state_next;
  logic [BAUD_W-1:0]  r_baud, w_baud_next;
  logic [BIT_W-1:0]   r_bit, w_bit_next;
  logic [DATA_W-1:0]  r_shift, w_shift_next;
  logic               r_par, w_par_next;
  logic               r_tx, w_tx_next;
  logic               r_done, w_done_next;
  logic               r_ovf;
  logic               r_busy;

  logic               w_rd_en;
  logic [DATA_W-1:0]  w_head;
  logic               w_head_par;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic               w_bit_end;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (bus.i_wr_en),
    .i_wr_data (bus.i_data),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Parity is captured with the word so the frame is immune to later writes.
  assign w_head_par = (PARITY == PAR_ODD) ? ~^w_head : ^w_head;
  assign w_bit_end  = (r_baud == BAUD_LAST);

  // TX and DONE are computed one clock ahead and registered, so each bit
  // changes exactly on the edge where the FSM changes state.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_bit_end ? '0 : r_baud + BAUD_W'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    w_tx_next    = r_tx;
    w_rd_en      = 1'b0;
    // Last clock of the final stop bit follows this one.
    w_done_next  = (r_state == S_STOP) && (r_baud == BAUD_PRE) && (r_bit == STOP_LAST);

    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (!w_empty) begin
          w_rd_en      = 1'b1;
          w_shift_next = w_head;
          w_par_next   = w_head_par;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
          w_shift_next = r_shift >> 1;
          w_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == DATA_LAST) begin
            w_bit_next = '0;
            if (PARITY != PAR_NONE) begin
              w_state_next = S_PAR;
              w_tx_next    = r_par;
            end else begin
              w_state_next = S_STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_next   = r_bit + BIT_W'(1);
            w_tx_next    = r_shift[0];
            w_shift_next = r_shift >> 1;
          end
        end
      end
      S_PAR: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
          w_bit_next   = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit == STOP_LAST) begin
            // Chain straight into the next start bit when words are queued.
            if (!w_empty) begin
              w_rd_en      = 1'b1;
              w_shift_next = w_head;
              w_par_next   = w_head_par;
              w_state_next = S_START;
              w_tx_next    = 1'b0;
            end else begin
              w_state_next = S_IDLE;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_next = r_bit + BIT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;  // line returns to idle the instant reset asserts
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
      r_ovf   <= bus.i_wr_en & w_full;
      r_busy  <= (w_state_next != S_IDLE) | (w_count != '0);
    end
  end

  assign bus.o_full = w_full;
  assign bus.o_busy = r_busy;
  assign bus.o_tx   = r_tx;
  assign bus.o_done = r_done;
  assign bus.o_ovf  = r_ovf;

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Directed bench for rs232_tx_fifo. Four instances cover the configurations
// exercised: A (8 bits, /4, no parity, 1 stop), B (even parity), C (odd
// parity), D (5 bits, /3, 2 stops). Expected line patterns are written out
// by hand as strings in transmission order, one character per bit.
module tb_rs232_tx_fifo;
  import rs232_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] drv_wr;
  logic [7:0] drv_data [4];
  wire  [3:0] mon_tx, mon_done, mon_busy, mon_full, mon_ovf;

  rs232_tx_fifo_if #(.DATA_W(8)) if_a ();
  rs232_tx_fifo_if #(.DATA_W(8)) if_b ();
  rs232_tx_fifo_if #(.DATA_W(8)) if_c ();
  rs232_tx_fifo_if #(.DATA_W(5)) if_d ();

  assign if_a.i_wr_en = drv_wr[0];
  assign if_b.i_wr_en = drv_wr[1];
  assign if_c.i_wr_en = drv_wr[2];
  assign if_d.i_wr_en = drv_wr[3];
  assign if_a.i_data  = drv_data[0];
  assign if_b.i_data  = drv_data[1];
  assign if_c.i_data  = drv_data[2];
  assign if_d.i_data  = drv_data[3][4:0];

  assign mon_tx   = {if_d.o_tx,   if_c.o_tx,   if_b.o_tx,   if_a.o_tx};
  assign mon_done = {if_d.o_done, if_c.o_done, if_b.o_done, if_a.o_done};
  assign mon_busy = {if_d.o_busy, if_c.o_busy, if_b.o_busy, if_a.o_busy};
  assign mon_full = {if_d.o_full, if_c.o_full, if_b.o_full, if_a.o_full};
  assign mon_ovf  = {if_d.o_ovf,  if_c.o_ovf,  if_b.o_ovf,  if_a.o_ovf};

  rs232_tx_fifo #(.DATA_W(8), .CLK_DIV(4), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));
  rs232_tx_fifo #(.DATA_W(8), .CLK_DIV(4), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b.slave));
  rs232_tx_fifo #(.DATA_W(8), .CLK_DIV(4), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c.slave));
  rs232_tx_fifo #(.DATA_W(5), .CLK_DIV(3), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_d (.i_clk(clk), .i_rst_n(rst_n), .bus(if_d.slave));

  // Called at a negedge: presents one word, accepted on the next rising edge.
  task automatic write_word(input int d, input logic [7:0] w);
    drv_data[d] = w;
    drv_wr[d]   = 1'b1;
    @(posedge clk);
    #1 drv_wr[d] = 1'b0;
  endtask

  // Clock 0 after the accepting edge: line must still be idle.
  task automatic check_latency(input int d, input string name);
    @(negedge clk);
    total++;
    if (mon_tx[d] !== 1'b1 || mon_busy[d] !== 1'b0) begin
      bad++;
      $display("FAIL %s: tx=%b busy=%b want tx=1 busy=0", name, mon_tx[d], mon_busy[d]);
    end
  endtask

  // Samples one frame starting with the next negedge; DONE must appear only in its last clock.
  task automatic capture_frame(input int d, input string bits, input int cdiv, input string name);
    int len;
    int done_n;
    int done_at;
    logic [63:0] obs;
    logic [63:0] expv;
    len     = bits.len() * cdiv;
    done_n  = 0;
    done_at = 0;
    obs     = '0;
    expv    = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      obs[c]  = mon_tx[d];
      expv[c] = (bits[c / cdiv] == "1");
      if (c == 0) begin
        total++;
        if (mon_busy[d] !== 1'b1) begin
          bad++;
          $display("FAIL %s_busy: busy=%b want 1", name, mon_busy[d]);
        end
      end
      if (mon_done[d] === 1'b1) begin
        done_n++;
        done_at = c + 1;
      end
    end
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s_tx: got %b want %b", name, obs, expv);
    end
    total++;
    if (done_n !== 1 || done_at !== len) begin
      bad++;
      $display("FAIL %s_done: pulses=%0d at clock %0d want 1 at clock %0d", name, done_n, done_at, len);
    end
  endtask

  // Clock after the final DONE: BUSY low, line idle.
  task automatic check_idle(input int d, input string name);
    @(negedge clk);
    total++;
    if ({mon_busy[d], mon_tx[d], mon_done[d]} !== 3'b010) begin
      bad++;
      $display("FAIL %s: busy=%b tx=%b done=%b want busy=0 tx=1 done=0",
               name, mon_busy[d], mon_tx[d], mon_done[d]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({mon_tx[d], mon_busy[d], mon_full[d], mon_done[d], mon_ovf[d]} !== 5'b10000) begin
        bad++;
        $display("FAIL reset_%0d: tx/busy/full/done/ovf=%b want 10000", d,
                 {mon_tx[d], mon_busy[d], mon_full[d], mon_done[d], mon_ovf[d]});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    write_word(0, 8'h55);
    check_latency(0, "basic_latency");
    capture_frame(0, "0101010101", 4, "basic");
    check_idle(0, "basic_end");
  endtask

  task automatic test_parity();
    write_word(1, 8'h07);
    check_latency(1, "even_latency");
    capture_frame(1, "01110000011", 4, "par_even");
    check_idle(1, "even_end");
    write_word(2, 8'h07);
    check_latency(2, "odd_latency");
    capture_frame(2, "01110000001", 4, "par_odd");
    check_idle(2, "odd_end");
  endtask

  task automatic test_narrow();
    write_word(3, 8'h1F);
    check_latency(3, "narrow_latency");
    capture_frame(3, "01111111", 3, "narrow");
    check_idle(3, "narrow_end");
  endtask

  task automatic test_fifo_full();
    string frames [5];
    frames = '{"0100010001", "0010001001", "0110011001", "0001000101", "0100110011"};
    drv_data[0] = 8'h11;
    drv_wr[0]   = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        @(negedge clk);
        for (int f = 0; f < 5; f++) capture_frame(0, frames[f], 4, $sformatf("fifo_frame%0d", f));
      end
      begin
        drv_data[0] = 8'h22;
        @(posedge clk);
        #1 drv_data[0] = 8'h33;
        @(posedge clk);
        #1 drv_data[0] = 8'h44;
        @(posedge clk);
        #1 drv_data[0] = 8'h99;
        @(negedge clk);
        total++;
        if (mon_full[0] !== 1'b0) begin
          bad++;
          $display("FAIL fifo_three: full=%b want 0", mon_full[0]);
        end
        @(posedge clk);
        #1 drv_data[0] = 8'hAA;
        @(negedge clk);
        total++;
        if (mon_full[0] !== 1'b1 || mon_ovf[0] !== 1'b0) begin
          bad++;
          $display("FAIL fifo_full: full=%b ovf=%b want full=1 ovf=0", mon_full[0], mon_ovf[0]);
        end
        @(posedge clk);
        #1 drv_wr[0] = 1'b0;
        @(negedge clk);
        total++;
        if (mon_ovf[0] !== 1'b1) begin
          bad++;
          $display("FAIL fifo_ovf: ovf=%b want 1", mon_ovf[0]);
        end
        @(negedge clk);
        total++;
        if (mon_ovf[0] !== 1'b0 || mon_full[0] !== 1'b1) begin
          bad++;
          $display("FAIL fifo_ovf_once: ovf=%b full=%b want ovf=0 full=1", mon_ovf[0], mon_full[0]);
        end
      end
    join
    check_idle(0, "fifo_end");
  endtask

  task automatic test_reset_mid_frame();
    int errs;
    drv_data[0] = 8'h11;
    drv_wr[0]   = 1'b1;
    @(posedge clk);
    #1 drv_data[0] = 8'h22;
    @(posedge clk);
    #1 drv_wr[0] = 1'b0;
    // Clock 18 of the frame lies in data bit 3 of 0x11, which is 0.
    repeat (18) @(negedge clk);
    total++;
    if (mon_tx[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre_reset: tx=%b want 0", mon_tx[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({mon_tx[0], mon_busy[0], mon_full[0], mon_done[0], mon_ovf[0]} !== 5'b10000) begin
      bad++;
      $display("FAIL mid_async: tx/busy/full/done/ovf=%b want 10000",
               {mon_tx[0], mon_busy[0], mon_full[0], mon_done[0], mon_ovf[0]});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (60) begin
      @(negedge clk);
      if (mon_tx[0] !== 1'b1 || mon_busy[0] !== 1'b0 || mon_done[0] !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL mid_quiet: %0d clocks with activity want 0", errs);
    end
    write_word(0, 8'hA5);
    check_latency(0, "mid_latency");
    capture_frame(0, "0101001011", 4, "mid_resend");
    check_idle(0, "mid_end");
  endtask

  initial begin
    drv_wr = '0;
    for (int d = 0; d < 4; d++) drv_data[d] = '0;
    test_reset();
    test_basic();
    test_parity();
    test_narrow();
    test_fifo_full();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs232_tx_fifo.md
# rs232_tx_fifo

Parametrised successor to the single-byte RS-232 transmitter. It buffers outgoing words in an internal FIFO and serialises them as standard asynchronous frames. Each frame has a start bit, DATA_W data bits (LSB first), optional odd/even parity and 1 or 2 stop bits, with every bit held for CLK_DIV clocks. It sits between the scoreboard/host logic and the board's TX pin and sends frames back-to-back with no CPU pacing.

## Interface
- DATA_W, 8: data bits per frame; legal 5..8.
- CLK_DIV, 16: clocks per bit; legal ≥2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of 2, ≥2.
- CLK_TX  in  1  sole clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- DATA  in  DATA_W  word to enqueue.
- WR_EN  in  1  enqueue request; accepted when FULL=0.
- FULL  out  1  FIFO holds FIFO_DEPTH entries.
- BUSY  out  1  frame in progress or FIFO non-empty.
- TX  out  1  serial line; idles high.
- DONE  out  1  one-cycle pulse in last clock of final stop bit.
- OVF  out  1  one-cycle pulse when WR_EN arrives while FULL=1.

## Operation
- Line polarity: idle = 1, start bit = 0, stop bits = 1. Data bits are sent LSB first.
- Parity bit: even = ^word; odd = ~^word. Only DATA_W bits are covered.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if FIFO non-empty, pop the head into a shift register, go to START, TX←0.
  - START: after CLK_DIV clocks go to DATA and drive bit 0.
  - DATA: shift each CLK_DIV clocks. After DATA_W bits go to PAR (PARITY≠0) or STOP.
  - PAR: hold the parity bit for CLK_DIV clocks, then go to STOP.
  - STOP: hold TX=1 for STOP_BITS×CLK_DIV clocks. In the last clock pulse DONE. Then pop the next word and go straight to START if the FIFO is non-empty, else go to IDLE.
- Counters:
  - Baud counter: $clog2(CLK_DIV) bits, counts 0..CLK_DIV−1 and wraps.
  - Bit counter: counts data bits, and stop bits during STOP.
- FIFO status: FULL and the empty flag derive from a registered count of width $clog2(FIFO_DEPTH)+1.
- Writes:
  - A write with FULL=1 is dropped and OVF pulses, even if a pop happens in the same cycle.
  - A write and a pop in the same cycle are both performed and the count is unchanged.
- DATA is sampled only on an accepting edge. Changes during a frame do not affect the frame in flight.
- Reset (RST_N=0, any time, including mid-frame):
  - TX=1 immediately, asynchronously.
  - DONE=0, OVF=0, BUSY=0, FULL=0.
  - FIFO emptied, FSM to IDLE, counters cleared.
  - Partial frame abandoned, with no DONE.

## Timing
- Write latency: a write accepted at edge k into an empty FIFO with the FSM in IDLE drives TX=0 from edge k+1.
- Frame length: (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLK_DIV clocks, exactly.
- Back-to-back frames: zero idle clocks between frames. The next start bit begins the clock after DONE.
- BUSY rises at edge k+1 and falls the clock after the final DONE when the FIFO is empty.
- FULL updates one clock after the accepting edge.
- All outputs are registered.

## Structure
- Shared package rs232_pkg:
  - Parity constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - FSM state encoding (3 bits).
  - A function for the frame-length calculation, reused by the receiver and benches.
- One sub-module, tx_fifo: synchronous FIFO with parameters DEPTH and WIDTH, ports wr_en/rd_en/full/empty/count.
- Top level: FSM, baud counter, bit counter, shift register, parity register.
- Expected total size: ~200–300 lines of RTL.

## Test plan
- Basic frame (DATA_W=8, CLK_DIV=4, no parity, 1 stop): write 0x55 → TX reads 0,1,0,1,0,1,0,1,0,1, each bit for 4 clocks. DONE pulses in clock 40 after the start. BUSY falls at clock 41.
- Parity (CLK_DIV=4, 0x07): with PARITY=2 (even) the parity bit is 1; with PARITY=1 (odd) it is 0. Frame = 44 clocks.
- FIFO full (FIFO_DEPTH=4): five writes in consecutive clocks of 0x11, 0x22, 0x33, 0x44, 0x99 → one entry is popped immediately, so all five are accepted and FULL asserts. A sixth write of 0xAA → OVF pulses once and 0xAA is never sent. Five frames go out contiguously, each DONE followed directly by a start bit.
- Narrow/two-stop (DATA_W=5, STOP_BITS=2, CLK_DIV=3): write 0x1F → 0, 1×5, 1×2. Frame = 24 clocks. DONE in clock 24.
- Reset mid-frame: assert RST_N=0 during data bit 3 → TX=1 in the same cycle. After release, TX stays 1, BUSY=0, no DONE, and queued words are discarded. A new write of 0xA5 is then sent correctly.
